// File: rtl/fpga_slave_spi_pkg.sv
// Shared definitions for the fpga_slave SPI command link: opcodes, byte-engine
// state encoding, default link timing and small helpers used by the master
// and by the slave-side decoder.
package fpga_slave_spi_pkg;

    // Command opcodes; bit 7 set means the opcode carries a 16-bit parameter.
    localparam logic [7:0] OP_TON   = 8'h91;
    localparam logic [7:0] OP_TOFF  = 8'h9E;
    localparam logic [7:0] OP_MODE  = 8'h9C;
    localparam logic [7:0] OP_IP    = 8'h93;
    localparam logic [7:0] OP_START = 8'h06;

    // Default link timing, in system clock cycles.
    localparam int unsigned DEF_CLK_DIV_HALF = 2;
    localparam int unsigned DEF_CS_SETUP     = 5;
    localparam int unsigned DEF_CS_HOLD      = 5;
    localparam int unsigned DEF_CS_GAP       = 5;

    // Phases of one chip-select framed byte transfer.
    typedef enum logic [2:0] {
        XS_IDLE,
        XS_SETUP,
        XS_SHIFT,
        XS_HOLD,
        XS_GAP
    } xfer_state_e;

    // Index of the final byte of a frame: opcode only, or opcode + 2 param bytes.
    function automatic logic [1:0] last_byte_idx(input logic [7:0] opcode);
        return opcode[7] ? 2'd2 : 2'd0;
    endfunction

    // Place one received byte into the 24-bit response word (byte 0 in [7:0]).
    function automatic logic [23:0] put_byte(input logic [23:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
        logic [23:0] w;
        w = word;
        case (idx)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            default: w[23:16] = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// One chip-select framed SPI byte (mode 0, MSB first): cs_n setup, eight
// SCLK periods, cs_n hold and a cs_n-high gap. done_o marks the edge that ends
// the gap; a start on that same edge chains straight into the next byte.
module spi_byte_xfer
    import fpga_slave_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV_HALF = DEF_CLK_DIV_HALF,
    parameter int unsigned CS_SETUP     = DEF_CS_SETUP,
    parameter int unsigned CS_HOLD      = DEF_CS_HOLD,
    parameter int unsigned CS_GAP       = DEF_CS_GAP
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] tx_i,
    output logic       done_o,
    output logic [7:0] rx_o,
    output logic       sclk_o,
    output logic       cs_n_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    // Down-counter reload values: a phase of N cycles loads N-1.
    localparam logic [15:0] SETUP_LD = 16'(CS_SETUP - 1);
    localparam logic [15:0] HALF_LD  = 16'(CLK_DIV_HALF - 1);
    localparam logic [15:0] HOLD_LD  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_LD   = 16'(CS_GAP - 1);

    xfer_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  half_q, half_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  rx_q, rx_d;

    assign done_o = (state_q == XS_GAP) && (cnt_q == 16'd0);
    assign rx_o   = rx_q;
    assign sclk_o = sclk_q;
    assign cs_n_o = cs_n_q;
    assign mosi_o = mosi_q;

    // Next-state and registered-output logic for the byte phases.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        case (state_q)
            XS_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (start_i) begin
                    state_d = XS_SETUP;
                    cs_n_d  = 1'b0;
                    cnt_d   = SETUP_LD;
                    sh_d    = tx_i;
                end
            end
            XS_SETUP: begin
                if (cnt_q == 16'd0) begin
                    // First low phase: present the MSB.
                    state_d = XS_SHIFT;
                    cnt_d   = HALF_LD;
                    half_d  = 4'd0;
                    sclk_d  = 1'b0;
                    mosi_d  = sh_q[7];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            XS_SHIFT: begin
                if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (half_q == 4'd15) begin
                    // Final falling edge ends the byte.
                    state_d = XS_HOLD;
                    sclk_d  = 1'b0;
                    cnt_d   = HOLD_LD;
                end else begin
                    half_d = half_q + 4'd1;
                    cnt_d  = HALF_LD;
                    if (!sclk_q) begin
                        // Rising edge: capture MISO.
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], miso_i};
                    end else begin
                        // Falling edge: advance to the next MOSI bit.
                        sclk_d = 1'b0;
                        sh_d   = {sh_q[6:0], 1'b0};
                        mosi_d = sh_q[6];
                    end
                end
            end
            XS_HOLD: begin
                if (cnt_q == 16'd0) begin
                    state_d = XS_GAP;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            XS_GAP: begin
                if (cnt_q == 16'd0) begin
                    if (start_i) begin
                        state_d = XS_SETUP;
                        cs_n_d  = 1'b0;
                        cnt_d   = SETUP_LD;
                        sh_d    = tx_i;
                    end else begin
                        state_d = XS_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = XS_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // Control state and SPI pins; reset parks the bus idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= XS_IDLE;
            cnt_q   <= 16'd0;
            half_q  <= 4'd0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

    // TX/RX shift registers carry data only and need no reset.
    always_ff @(posedge clk_i) begin
        sh_q <= sh_d;
        rx_q <= rx_d;
    end

endmodule

// File: rtl/spi_cmd_master.sv
// SPI command initiator for the fpga_slave port. Accepts opcode + 16-bit
// parameter, sends opcode (and param low, param high when opcode[7] is set)
// as separate chip-select windows, and returns the captured MISO bytes.
module spi_cmd_master
    import fpga_slave_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV_HALF = DEF_CLK_DIV_HALF,
    parameter int unsigned CS_SETUP     = DEF_CS_SETUP,
    parameter int unsigned CS_HOLD      = DEF_CS_HOLD,
    parameter int unsigned CS_GAP       = DEF_CS_GAP
) (
    input  logic        clk_in,
    input  logic        sys_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [15:0] cmd_param,
    output logic        rsp_valid,
    output logic [23:0] rsp_data,
    output logic        busy,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    logic        ready_q, ready_d;
    logic        active_q, active_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_q, last_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [23:0] rsp_data_q, rsp_data_d;
    logic [23:0] acc_q, acc_d;
    logic [15:0] param_q, param_d;

    logic        accept;
    logic        xfer_start;
    logic [7:0]  xfer_tx;
    logic        xfer_done;
    logic [7:0]  xfer_rx;
    logic [23:0] merged;

    assign cmd_ready = ready_q;
    assign busy      = ~ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    spi_byte_xfer #(
        .CLK_DIV_HALF(CLK_DIV_HALF),
        .CS_SETUP    (CS_SETUP),
        .CS_HOLD     (CS_HOLD),
        .CS_GAP      (CS_GAP)
    ) u_xfer (
        .clk_i  (clk_in),
        .rst_i  (sys_rst),
        .start_i(xfer_start),
        .tx_i   (xfer_tx),
        .done_o (xfer_done),
        .rx_o   (xfer_rx),
        .sclk_o (sclk),
        .cs_n_o (cs_n),
        .mosi_o (mosi),
        .miso_i (miso)
    );

    // Frame sequencing: accept, chain bytes on each byte-done, publish response.
    always_comb begin
        ready_d     = ready_q;
        active_d    = active_q;
        idx_d       = idx_q;
        last_d      = last_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        acc_d       = acc_q;
        param_d     = param_q;
        xfer_start  = 1'b0;
        xfer_tx     = cmd_opcode;
        accept      = cmd_valid && ready_q;
        merged      = put_byte(acc_q, idx_q, xfer_rx);
        // Leaving reset with no frame in flight raises ready on the next edge.
        if (!active_q) begin
            ready_d = 1'b1;
        end
        if (accept) begin
            // Opcode goes out directly so cs_n falls on the acceptance edge.
            ready_d    = 1'b0;
            active_d   = 1'b1;
            param_d    = cmd_param;
            last_d     = last_byte_idx(cmd_opcode);
            idx_d      = 2'd0;
            acc_d      = 24'd0;
            xfer_start = 1'b1;
            xfer_tx    = cmd_opcode;
        end else if (active_q && xfer_done) begin
            acc_d = merged;
            if (idx_q == last_q) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = merged;
                active_d    = 1'b0;
                ready_d     = 1'b1;
            end else begin
                idx_d      = idx_q + 2'd1;
                xfer_start = 1'b1;
                xfer_tx    = (idx_q == 2'd0) ? param_q[7:0] : param_q[15:8];
            end
        end
    end

    // Control and response registers; reset drops any frame in flight.
    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            ready_q     <= 1'b0;
            active_q    <= 1'b0;
            idx_q       <= 2'd0;
            last_q      <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 24'd0;
        end else begin
            ready_q     <= ready_d;
            active_q    <= active_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Latched parameter and partial response are pure data.
    always_ff @(posedge clk_in) begin
        param_q <= param_d;
        acc_q   <= acc_d;
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: records SPI bus events with cycle stamps and
// compares each frame against timing and data derived from the link rules.
module tb_spi_cmd_master;
    import fpga_slave_spi_pkg::*;

    localparam int unsigned HALF   = 2;
    localparam int unsigned SETUP  = 5;
    localparam int unsigned HOLD   = 5;
    localparam int unsigned GAP    = 5;
    localparam int unsigned BYTE_T = SETUP + 16 * HALF + HOLD + GAP;

    logic        clk_in = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = 8'h00;
    logic [15:0] cmd_param = 16'h0000;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic        busy;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;

    logic        loop_mode = 1'b0;
    logic        miso_r = 1'b0;
    logic [7:0]  sreg = 8'h00;
    logic        prev_cs_n = 1'b1;
    logic        prev_sclk = 1'b0;

    int unsigned cyc = 0;
    int unsigned fall_q[$];
    int unsigned rise_q[$];
    int unsigned srise_q[$];
    int unsigned rspc_q[$];
    logic        bit_q[$];
    logic [23:0] rspd_q[$];
    logic [7:0]  slv_q[$];

    int total = 0;
    int bad = 0;

    always #10 clk_in = ~clk_in;

    assign miso = loop_mode ? mosi : miso_r;

    spi_cmd_master #(
        .CLK_DIV_HALF(HALF),
        .CS_SETUP    (SETUP),
        .CS_HOLD     (HOLD),
        .CS_GAP      (GAP)
    ) dut (
        .clk_in    (clk_in),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_param (cmd_param),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso)
    );

    always @(posedge clk_in) cyc <= cyc + 1;

    // Bus monitor plus mode-0 slave that shifts its byte out on SCLK falls.
    always @(negedge clk_in) begin
        if (prev_cs_n && !cs_n) begin
            fall_q.push_back(cyc);
            sreg = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
            miso_r = sreg[7];
        end
        if (!prev_cs_n && cs_n) rise_q.push_back(cyc);
        if (!prev_sclk && sclk) begin
            srise_q.push_back(cyc);
            bit_q.push_back(mosi);
        end
        if (prev_sclk && !sclk) begin
            sreg = {sreg[6:0], 1'b0};
            miso_r = sreg[7];
        end
        if (rsp_valid) begin
            rspc_q.push_back(cyc);
            rspd_q.push_back(rsp_data);
        end
        prev_cs_n = cs_n;
        prev_sclk = sclk;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        fall_q.delete(); rise_q.delete(); srise_q.delete(); rspc_q.delete();
        bit_q.delete(); rspd_q.delete();
    endtask

    function automatic logic [7:0] sent_byte(input logic [7:0] op, input logic [15:0] prm, input int unsigned n);
        if (n == 0) return op;
        if (n == 1) return prm[7:0];
        return prm[15:8];
    endfunction

    function automatic logic [23:0] pack3(input int unsigned n, input logic [7:0] b0,
                                          input logic [7:0] b1, input logic [7:0] b2);
        return (n == 3) ? {b2, b1, b0} : {16'h0000, b0};
    endfunction

    // Present a command and wait for acceptance; e0 is the acceptance edge.
    task automatic issue(input logic [7:0] op, input logic [15:0] prm, output int unsigned e0);
        bit got;
        got = 1'b0;
        cmd_opcode = op;
        cmd_param = prm;
        cmd_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("accept_wait", 32'(got), 32'd1);
        tick();
        e0 = cyc;
    endtask

    // Wait for the response and check every recorded bus event of the frame.
    task automatic check_frame(input int unsigned e0, input logic [7:0] op,
                               input logic [15:0] prm, input logic [23:0] exp_rsp);
        int unsigned n;
        int unsigned errs;
        int unsigned t;
        bit got;
        logic [7:0] b;
        n = op[7] ? 3 : 1;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rspc_q.size() > 0) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("rsp_wait", 32'(got), 32'd1);
        if (!got) begin
            clear_q();
            return;
        end
        chk("rsp_cycle", rspc_q.pop_front(), e0 + n * BYTE_T);
        chk("rsp_data", 32'(rspd_q.pop_front()), 32'(exp_rsp));
        chk("ready_at_end", 32'(cmd_ready), 32'd1);
        chk("n_cs_fall", 32'(fall_q.size()), n);
        chk("n_cs_rise", 32'(rise_q.size()), n);
        chk("n_bits", 32'(bit_q.size()), 8 * n);
        if (fall_q.size() == n && rise_q.size() == n && bit_q.size() == 8 * n
            && srise_q.size() == 8 * n) begin
            for (int unsigned k = 0; k < n; k++) begin
                chk("cs_fall", fall_q.pop_front(), e0 + k * BYTE_T);
                chk("cs_rise", rise_q.pop_front(), e0 + k * BYTE_T + BYTE_T - GAP);
                b = 8'h00;
                errs = 0;
                for (int unsigned j = 0; j < 8; j++) begin
                    b = {b[6:0], bit_q.pop_front()};
                    t = srise_q.pop_front();
                    if (t != e0 + k * BYTE_T + SETUP + HALF + 2 * HALF * j) errs++;
                end
                chk("mosi_byte", 32'(b), 32'(sent_byte(op, prm, k)));
                chk("sclk_rise_times", errs, 0);
            end
        end
        clear_q();
        tick();
        chk("rsp_pulse_len", 32'(rsp_valid), 32'd0);
    endtask

    // One complete frame with either loopback MISO or the shifting slave.
    task automatic do_frame(input logic [7:0] op, input logic [15:0] prm,
                            input logic lm, input logic [23:0] sb);
        int unsigned e0;
        int unsigned n;
        logic [23:0] exp_rsp;
        n = op[7] ? 3 : 1;
        slv_q.push_back(sb[7:0]);
        if (n == 3) begin
            slv_q.push_back(sb[15:8]);
            slv_q.push_back(sb[23:16]);
        end
        loop_mode = lm;
        exp_rsp = lm ? pack3(n, op, prm[7:0], prm[15:8]) : pack3(n, sb[7:0], sb[15:8], sb[23:16]);
        issue(op, prm, e0);
        cmd_valid = 1'b0;
        chk("busy_in_frame", 32'(busy), 32'd1);
        check_frame(e0, op, prm, exp_rsp);
    endtask

    initial begin
        int unsigned e0a;
        int unsigned e0r;
        logic [7:0]  op;
        logic [15:0] prm;
        logic [23:0] sa;
        logic [23:0] sbb;

        // Reset state.
        sys_rst = 1'b1;
        repeat (3) tick();
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        sys_rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);
        chk("busy_after_rst", 32'(busy), 32'd0);
        clear_q();
        slv_q.delete();

        // Ton frame, three windows, random slave bytes.
        do_frame(OP_TON, 16'h0064, 1'b0, 24'($urandom));
        // Start command: single window, param ignored.
        do_frame(OP_START, 16'hFFFF, 1'b0, 24'($urandom));
        // MISO looped back from MOSI.
        do_frame(OP_IP, 16'h003C, 1'b1, 24'h000000);
        // Slave shifts 0xA5 for a one-byte command.
        do_frame(8'h1C, 16'h1234, 1'b0, 24'h0000A5);

        // Back-to-back with cmd_valid held high throughout.
        sa = 24'($urandom);
        sbb = 24'($urandom);
        prm = 16'($urandom);
        slv_q.push_back(sa[7:0]);  slv_q.push_back(sa[15:8]);  slv_q.push_back(sa[23:16]);
        slv_q.push_back(sbb[7:0]); slv_q.push_back(sbb[15:8]); slv_q.push_back(sbb[23:16]);
        loop_mode = 1'b0;
        issue(OP_TOFF, 16'h0032, e0a);
        cmd_opcode = OP_MODE;
        cmd_param = prm;
        check_frame(e0a, OP_TOFF, 16'h0032, sa);
        cmd_valid = 1'b0;
        chk("b2b_second_busy", 32'(busy), 32'd1);
        check_frame(e0a + 3 * BYTE_T + 1, OP_MODE, prm, sbb);

        // Reset pulsed during byte 1 of a three-byte frame.
        slv_q.delete();
        issue(OP_TON, 16'($urandom), e0r);
        cmd_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cyc >= e0r + BYTE_T + 20) break;
            tick();
        end
        chk("midrst_in_byte1", 32'(cs_n), 32'd0);
        sys_rst = 1'b1;
        tick();
        chk("midrst_cs_n", 32'(cs_n), 32'd1);
        chk("midrst_sclk", 32'(sclk), 32'd0);
        chk("midrst_mosi", 32'(mosi), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd0);
        sys_rst = 1'b0;
        tick();
        chk("midrst_ready_after", 32'(cmd_ready), 32'd1);
        clear_q();
        slv_q.delete();
        repeat (200) tick();
        chk("midrst_no_rsp", 32'(rspc_q.size()), 32'd0);
        chk("midrst_no_cs", 32'(fall_q.size()), 32'd0);
        chk("midrst_rsp_data", 32'(rsp_data), 32'd0);

        // Randomized frames of both lengths and both MISO sources.
        for (int r = 0; r < 8; r++) begin
            op = 8'($urandom);
            op[7] = r[0];
            do_frame(op, 16'($urandom), 1'($urandom_range(0, 1)), 24'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_master.md
# spi_cmd_master

Synthesizable SPI initiator that issues command frames to the `fpga_slave` SPI port: Ton, Toff, mode, Ip, start and stop commands. It accepts one opcode plus a 16-bit parameter per handshake and serializes it as one or three byte-framed SPI transfers (mode 0, MSB first). It captures MISO during every transfer. It sits in the host or controller FPGA and also serves as the synthesizable stimulus master in system-level benches.

## Interface
Parameters:
- `CLK_DIV_HALF`, 2: clk_in cycles per SCLK half-period (≥1).
- `CS_SETUP`, 5: cycles from cs_n low to the first SCLK low phase (≥1).
- `CS_HOLD`, 5: cycles after the last SCLK fall before cs_n rises (≥1).
- `CS_GAP`, 5: cycles cs_n stays high after each byte (≥1).

Ports:
- `clk_in` in 1: system clock, 50 MHz. One clock domain.
- `sys_rst` in 1: synchronous reset, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: idle and able to accept a command.
- `cmd_opcode` in 8: command opcode.
- `cmd_param` in 16: command parameter; sent low byte first.
- `rsp_valid` out 1: one-cycle pulse at frame completion.
- `rsp_data` out 24: captured MISO bytes; byte0 is in [7:0].
- `busy` out 1: equals ~cmd_ready.
- `sclk` out 1: SPI clock, idles low.
- `cs_n` out 1: chip select, active-low, one window per byte.
- `mosi` out 1: serial data to the slave.
- `miso` in 1: serial data from the slave.

## Operation
- **Handshake.** A command is accepted on the edge where cmd_valid && cmd_ready. On acceptance, cmd_opcode and cmd_param are latched. cmd_valid is ignored while busy.
- **Frame length.** If cmd_opcode[7] = 1, the frame is 3 bytes: opcode, param[7:0], param[15:8]. If cmd_opcode[7] = 0, the frame is 1 byte: opcode only.
- **FSM states.** IDLE → SETUP → SHIFT → HOLD → GAP → (SETUP if bytes remain, else IDLE).
  - **SETUP:** cs_n=0, sclk=0 for CS_SETUP cycles.
  - **SHIFT:** 8 bits, MSB first. Each bit is a low phase then a high phase, each CLK_DIV_HALF cycles. mosi updates on the first cycle of each low phase. miso is sampled on the edge where sclk rises.
  - **HOLD:** sclk=0, cs_n=0 for CS_HOLD cycles.
  - **GAP:** cs_n=1 for CS_GAP cycles.
- **Response.** Captured bytes are packed into rsp_data. Unused upper bytes are 0 for 1-byte frames. rsp_data holds its value until the next rsp_valid.
- **Reset values:** cmd_ready=0 while sys_rst=1, then 1 on the first edge after release. cs_n=1, sclk=0, mosi=0, rsp_valid=0, rsp_data=0, busy=1 during reset.
- **Reset mid-frame.** The next edge forces cs_n=1, sclk=0, mosi=0 and returns the FSM to IDLE. The frame is dropped and no rsp_valid is issued.

## Timing
- **Reference edge.** E0 is the acceptance edge. At E0: cs_n→0, cmd_ready→0, busy→1.
- **Byte period.** B = CS_SETUP + 16·CLK_DIV_HALF + CS_HOLD + CS_GAP, which is 47 cycles at the defaults.
- **Byte n (from 0).** cs_n falls at E0 + n·B. The first sclk rise is at E0 + n·B + CS_SETUP + CLK_DIV_HALF. cs_n rises at E0 + n·B + B − CS_GAP.
- **Frame end.** At E0 + N·B (N = 1 or 3), rsp_valid=1 for one cycle and cmd_ready=1.
- **Back-to-back.** The earliest next acceptance is the edge E0 + N·B + 1, so frames are separated by at least CS_GAP cycles of cs_n high.
- **Default SPI timing.** SCLK period is 80 ns. MOSI setup to the rising edge is CLK_DIV_HALF cycles (40 ns).

## Structure
- **Package `fpga_slave_spi_pkg`:**
  - Opcode constants: OP_TON=8'h91, OP_TOFF=8'h9E, OP_MODE=8'h9C, OP_IP=8'h93, OP_START=8'h06.
  - FSM state encoding.
  - Default timing constants.
  - The slave-side decoder imports the same package.
- **Sub-module `spi_byte_xfer`:**
  - Handles one CS-framed byte: SETUP, SHIFT, HOLD and GAP, with start/done handshake and an 8-bit TX/RX path.
  - The top level sequences bytes, counts them and assembles the response.

## Test plan
- **Ton frame.** Opcode 0x91, param 0x0064 → three cs_n windows; MOSI bytes 91, 64, 00 MSB first; cs_n falls at E0, E0+47, E0+94; rsp_valid at E0+141.
- **Start command.** Opcode 0x06, param 0xFFFF → single window, cs_n low for 42 cycles, MOSI byte 06 only, rsp_valid at E0+47.
- **MISO loopback.** miso tied to mosi with Ip command 0x93/0x003C → rsp_data = 24'h003C93.
- **MISO sampling.** Slave model shifts 0xA5 on sclk falling edges, 1-byte command → rsp_data = 24'h0000A5.
- **Busy and back-to-back.** cmd_valid held high through a 0x9E/0x0032 frame → no second acceptance before E0+141; second command accepted at E0+142; cs_n high ≥5 cycles between frames.
- **Reset mid-frame.** sys_rst pulsed during byte 1 of a 3-byte frame → cs_n=1, sclk=0, mosi=0 on the next edge; no rsp_valid; cmd_ready=1 one cycle after release.
